// File: rtl/palette_mapper.sv
// Layer compositor plus writable palette lookup for the VGA path: two-stage pipeline, registered RGB.
// Optional build macro PALETTE_FADE_EN enables per-pixel brightness shift via the fade port.
module palette_mapper #(
  parameter int unsigned CODE_W      = 6,
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned TRANSP_CODE = 0,
  parameter int unsigned BG_CODE     = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         pix_valid_in,
  input  logic [NUM_LAYERS*CODE_W-1:0] layer_code,
  input  logic                         pal_we,
  input  logic [CODE_W-1:0]            pal_addr,
  input  logic [23:0]                  pal_wdata,
  input  logic [2:0]                   fade,
  output logic                         pix_valid_out,
  output logic                         pix_transparent,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B
);

  localparam int unsigned DEPTH = 2 ** CODE_W;
  localparam int unsigned RGB_W = 24;

  function automatic logic [RGB_W-1:0] pal_default(input int unsigned idx);
    case (idx)
      0, 1:    pal_default = 24'h000000;
      2:       pal_default = 24'h27b212;
      3:       pal_default = 24'hd80222;
      4:       pal_default = 24'h5db1f0;
      5:       pal_default = 24'hf1ff0a;
      6:       pal_default = 24'hb2b2b0;
      7:       pal_default = 24'hf27a00;
      8:       pal_default = 24'h663300;
      9:       pal_default = 24'h8600b3;
      10:      pal_default = 24'h000066;
      11:      pal_default = 24'hffffff;
      default: pal_default = 24'hb2b2b0;
    endcase
  endfunction

  logic [RGB_W-1:0]  pal_q [DEPTH];

  logic              s1_valid_q, s1_transp_q;
  logic [CODE_W-1:0] s1_code_q;
  logic              sel_transp_d, sel_found;
  logic [CODE_W-1:0] sel_code_d;

  logic              s2_valid_q, s2_transp_q;
  logic [RGB_W-1:0]  s2_rgb_q, s2_rgb_d;

  // Highest-priority (lowest index) non-transparent layer wins; else background.
  always_comb begin
    sel_code_d   = CODE_W'(BG_CODE);
    sel_transp_d = 1'b1;
    sel_found    = 1'b0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (!sel_found && layer_code[i*CODE_W +: CODE_W] != CODE_W'(TRANSP_CODE)) begin
        sel_code_d   = layer_code[i*CODE_W +: CODE_W];
        sel_transp_d = 1'b0;
        sel_found    = 1'b1;
      end
    end
  end

`ifdef PALETTE_FADE_EN
  logic [2:0] s1_fade_q;

  always_ff @(posedge Clk) begin
    if (Reset) s1_fade_q <= 3'd0;
    else       s1_fade_q <= fade;
  end

  always_comb begin
    s2_rgb_d = '0;
    if (s1_valid_q) begin
      s2_rgb_d = {pal_q[s1_code_q][23:16] >> s1_fade_q,
                  pal_q[s1_code_q][15:8]  >> s1_fade_q,
                  pal_q[s1_code_q][7:0]   >> s1_fade_q};
    end
  end
`else
  logic unused_fade;
  assign unused_fade = ^fade;

  always_comb begin
    s2_rgb_d = '0;
    if (s1_valid_q) s2_rgb_d = pal_q[s1_code_q];
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_transp_q <= 1'b0;
      s1_code_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_transp_q <= 1'b0;
      s2_rgb_q    <= '0;
    end else begin
      s1_valid_q  <= pix_valid_in;
      s1_transp_q <= sel_transp_d;
      s1_code_q   <= sel_code_d;
      s2_valid_q  <= s1_valid_q;
      s2_transp_q <= s1_valid_q & s1_transp_q;
      s2_rgb_q    <= s2_rgb_d;
    end
  end

  // Nonblocking write: a stage-2 read of the same entry on this edge sees the old value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) pal_q[i] <= pal_default(i);
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_wdata;
    end
  end

  assign pix_valid_out   = s2_valid_q;
  assign pix_transparent = s2_transp_q;
  assign VGA_R           = s2_rgb_q[23:16];
  assign VGA_G           = s2_rgb_q[15:8];
  assign VGA_B           = s2_rgb_q[7:0];

endmodule

// File: tb/tb_palette_mapper.sv
// Self-checking bench for palette_mapper: directed scenarios then randomized traffic
// against a cycle-level reference model of the composite/palette behaviour.
module tb_palette_mapper;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned NL     = 2;

  logic              Clk = 1'b0;
  logic              Reset, pix_valid_in, pal_we;
  logic [NL*CODE_W-1:0] layer_code;
  logic [CODE_W-1:0] pal_addr;
  logic [23:0]       pal_wdata;
  logic [2:0]        fade;
  logic              pix_valid_out, pix_transparent;
  logic [7:0]        VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int errors = 0;

  logic [23:0] base_tbl [12] = '{24'h000000, 24'h000000, 24'h27b212, 24'hd80222,
                                 24'h5db1f0, 24'hf1ff0a, 24'hb2b2b0, 24'hf27a00,
                                 24'h663300, 24'h8600b3, 24'h000066, 24'hffffff};
  logic [23:0] pal_m [64];
  logic        m_v, m_t;
  logic [5:0]  m_code;
  logic [2:0]  m_fade;

  always #5 Clk = ~Clk;

  palette_mapper dut (
    .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in), .layer_code(layer_code),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .fade(fade),
    .pix_valid_out(pix_valid_out), .pix_transparent(pix_transparent),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  function automatic logic [23:0] shade(input logic [23:0] c, input logic [2:0] f);
`ifdef PALETTE_FADE_EN
    return {c[23:16] >> f, c[15:8] >> f, c[7:0] >> f};
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) pal_m[i] = (i < 12) ? base_tbl[i] : 24'hb2b2b0;
    m_v = 1'b0; m_t = 1'b0; m_code = '0; m_fade = '0;
  endtask

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %06h expected %06h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare all outputs.
  task automatic step(input logic rst, input logic v, input logic [5:0] c0, input logic [5:0] c1,
                      input logic we, input logic [5:0] a, input logic [23:0] d, input logic [2:0] f);
    logic        e_v, e_t;
    logic [23:0] e_rgb;
    Reset = rst; pix_valid_in = v; layer_code = {c1, c0};
    pal_we = we; pal_addr = a; pal_wdata = d; fade = f;
    @(posedge Clk);
    #1;
    if (rst) begin
      e_v = 1'b0; e_t = 1'b0; e_rgb = '0;
      model_reset();
    end else begin
      e_v   = m_v;
      e_t   = m_v & m_t;
      e_rgb = m_v ? shade(pal_m[m_code], m_fade) : 24'h0;
      if (we) pal_m[a] = d;
      m_v    = v;
      m_fade = f;
      if (c0 != 6'd0)      begin m_code = c0;   m_t = 1'b0; end
      else if (c1 != 6'd0) begin m_code = c1;   m_t = 1'b0; end
      else                 begin m_code = 6'd1; m_t = 1'b1; end
    end
    check("valid",  {23'd0, pix_valid_out},   {23'd0, e_v});
    check("transp", {23'd0, pix_transparent}, {23'd0, e_t});
    check("rgb",    {VGA_R, VGA_G, VGA_B},    e_rgb);
  endtask

  task automatic pix(input logic [5:0] c0, input logic [5:0] c1);
    step(1'b0, 1'b1, c0, c1, 1'b0, 6'd0, 24'd0, 3'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 24'd0, 3'd0);
  endtask

  task automatic rst_cycle();
    step(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 24'd0, 3'd0);
  endtask

  initial begin
    model_reset();
    // Reset held, then idle: everything stays zero.
    rst_cycle(); rst_cycle();
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    check("rst_valid", {23'd0, pix_valid_out}, 24'h0);
    idle(); idle();
    check("idle_valid", {23'd0, pix_valid_out}, 24'h0);

    // Layer 0 wins, two-cycle latency.
    pix(6'd3, 6'd2); idle();
    check("t2_rgb", {VGA_R, VGA_G, VGA_B}, 24'hd80222);
    check("t2_valid", {23'd0, pix_valid_out}, 24'h1);

    // Layer 0 transparent falls through; all transparent gives background.
    pix(6'd0, 6'd4); pix(6'd0, 6'd0);
    check("t3_l1", {VGA_R, VGA_G, VGA_B}, 24'h5db1f0);
    idle();
    check("t3_bg", {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check("t3_transp", {23'd0, pix_transparent}, 24'h1);

    // Write collides with the stage-2 read of the same entry.
    pix(6'd12, 6'd0);
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd12, 24'h123456, 3'd0);
    check("t4_old", {VGA_R, VGA_G, VGA_B}, 24'hb2b2b0);
    pix(6'd12, 6'd0); idle();
    check("t4_new", {VGA_R, VGA_G, VGA_B}, 24'h123456);
    rst_cycle(); pix(6'd12, 6'd0); idle();
    check("t4_reload", {VGA_R, VGA_G, VGA_B}, 24'hb2b2b0);

    // Reset outranks a same-cycle write.
    step(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 6'd3, 24'habcdef, 3'd0);
    pix(6'd3, 6'd0); idle();
    check("t4_rst_we", {VGA_R, VGA_G, VGA_B}, 24'hd80222);

    // Back-to-back stream with a gap, then reset mid-stream.
    pix(6'd2, 6'd0); pix(6'd5, 6'd0);
    check("t5_a", {VGA_R, VGA_G, VGA_B}, 24'h27b212);
    idle();
    check("t5_b", {VGA_R, VGA_G, VGA_B}, 24'hf1ff0a);
    pix(6'd11, 6'd0);
    check("t5_gap", {VGA_R, VGA_G, VGA_B}, 24'h0);
    idle();
    check("t5_c", {VGA_R, VGA_G, VGA_B}, 24'hffffff);
    pix(6'd3, 6'd0); rst_cycle(); idle();
    check("t5_flush", {23'd0, pix_valid_out}, 24'h0);

    // Fade on code 11.
    step(1'b0, 1'b1, 6'd11, 6'd0, 1'b0, 6'd0, 24'd0, 3'd1);
    step(1'b0, 1'b1, 6'd11, 6'd0, 1'b0, 6'd0, 24'd0, 3'd7);
`ifdef PALETTE_FADE_EN
    check("t6_f1", {VGA_R, VGA_G, VGA_B}, 24'h7f7f7f);
`else
    check("t6_f1", {VGA_R, VGA_G, VGA_B}, 24'hffffff);
`endif
    idle();
`ifdef PALETTE_FADE_EN
    check("t6_f7", {VGA_R, VGA_G, VGA_B}, 24'h010101);
`else
    check("t6_f7", {VGA_R, VGA_G, VGA_B}, 24'hffffff);
`endif

    // Randomized traffic with writes, transparency and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] c0, c1;
      c0 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      c1 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      step(($urandom_range(0, 39) == 0), 1'($urandom), c0, c1,
           ($urandom_range(0, 3) == 0), 6'($urandom), 24'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
